// File: rtl/aes_pkg.sv
// Shared definitions for the AES round scheduler: FSM states, key-size
// encodings and round counts.
package aes_pkg;

  typedef enum logic [2:0] {
    IDLE,
    KEYEXP,
    KEYWAIT,
    ISSUE,
    RWAIT,
    FINISH,
    ERR
  } schedState_t;

  localparam logic [2:0] KEY_SIZE_128 = 3'b001;
  localparam logic [2:0] KEY_SIZE_192 = 3'b010;
  localparam logic [2:0] KEY_SIZE_256 = 3'b100;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  // Any encoding other than 192/256 is treated as a 128-bit key.
  function automatic logic [3:0] roundsFor(input logic [2:0] keySize);
    case (keySize)
      KEY_SIZE_256: return NR_256;
      KEY_SIZE_192: return NR_192;
      default:      return NR_128;
    endcase
  endfunction

endpackage

// File: rtl/aes_round_scheduler_if.sv
// Control handshake between a block requester, the key expander, the round
// engine and the round scheduler.
interface aes_round_scheduler_if;
  logic       start;
  logic       enc_or_dec;
  logic [2:0] key_size;
  logic       key_reload;
  logic       keyexp_start;
  logic       keyexp_done;
  logic       round_start;
  logic       round_done;
  logic [3:0] round_idx;
  logic [3:0] key_sel;
  logic       initial_round;
  logic       final_round;
  logic       load_msg;
  logic       capture_out;
  logic       busy;
  logic       done;
  logic       error;

  modport slave (
    input  start, enc_or_dec, key_size, key_reload, keyexp_done, round_done,
    output keyexp_start, round_start, round_idx, key_sel, initial_round,
           final_round, load_msg, capture_out, busy, done, error
  );

  modport master (
    output start, enc_or_dec, key_size, key_reload, keyexp_done, round_done,
    input  keyexp_start, round_start, round_idx, key_sel, initial_round,
           final_round, load_msg, capture_out, busy, done, error
  );
endinterface

// File: rtl/aes_timeout_counter.sv
// Handshake watchdog: counts wait cycles and flags expiry at TIMEOUT_CYCLES-1.
module aes_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] LastCount = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] count;

  assign expired = enable && (count == LastCount);

  // Saturates at the terminal count so a held enable cannot wrap around.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LastCount)) begin
      count <= count + CntW'(1);
    end
  end

endmodule

// File: rtl/aes_round_scheduler.sv
// Sequences key expansion and Nr+1 round issues for one AES block.
// state   | meaning
// IDLE    | waiting for start
// KEYEXP  | pulse keyexp_start
// KEYWAIT | waiting for keyexp_done
// ISSUE   | pulse round_start for round_idx
// RWAIT   | waiting for round_done
// FINISH  | pulse done/capture_out
// ERR     | handshake timeout, flag error
module aes_round_scheduler
  import aes_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                  clk,
  input logic                  rst,
  aes_round_scheduler_if.slave bus
);

  schedState_t state, nextState;

  logic [3:0] roundIdx;
  logic [3:0] nrLat;
  logic [3:0] heldNr;
  logic       encLat;
  logic       keyValid;
  logic       errorFlag;
  logic       expired;
  logic       inRound;
  logic       needKeyExp;

  aes_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) uTimeout (
    .clk    (clk),
    .rst    (rst),
    .clear  ((state == KEYEXP) || (state == ISSUE)),
    .enable ((state == KEYWAIT) || (state == RWAIT)),
    .expired(expired)
  );

  assign needKeyExp = bus.key_reload || !keyValid || (roundsFor(bus.key_size) != heldNr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  // A handshake on the expiry cycle takes priority over the timeout.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (bus.start) nextState = needKeyExp ? KEYEXP : ISSUE;
      KEYEXP:  nextState = KEYWAIT;
      KEYWAIT: begin
        if (bus.keyexp_done) nextState = ISSUE;
        else if (expired)    nextState = ERR;
      end
      ISSUE:   nextState = RWAIT;
      RWAIT: begin
        if (bus.round_done) nextState = (roundIdx == nrLat) ? FINISH : ISSUE;
        else if (expired)   nextState = ERR;
      end
      FINISH:  nextState = IDLE;
      ERR:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      roundIdx  <= '0;
      nrLat     <= '0;
      heldNr    <= '0;
      encLat    <= 1'b0;
      keyValid  <= 1'b0;
      errorFlag <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          encLat    <= bus.enc_or_dec;
          nrLat     <= roundsFor(bus.key_size);
          errorFlag <= 1'b0;
          roundIdx  <= '0;
        end
        KEYWAIT: if (bus.keyexp_done) begin
          keyValid <= 1'b1;
          heldNr   <= nrLat;
        end
        RWAIT: if (bus.round_done && (roundIdx != nrLat)) roundIdx <= roundIdx + 4'd1;
        FINISH: roundIdx <= '0;
        ERR: begin
          keyValid <= 1'b0;
          roundIdx <= '0;
        end
        default: ;
      endcase
      if (nextState == ERR) errorFlag <= 1'b1;
    end
  end

  // Round-type flags and key select are only meaningful while a round is live.
  assign inRound           = (state == ISSUE) || (state == RWAIT);
  assign bus.keyexp_start  = (state == KEYEXP);
  assign bus.round_start   = (state == ISSUE);
  assign bus.round_idx     = roundIdx;
  assign bus.key_sel       = !inRound ? 4'd0 : (encLat ? roundIdx : (nrLat - roundIdx));
  assign bus.initial_round = inRound && (roundIdx == 4'd0);
  assign bus.final_round   = inRound && (roundIdx == nrLat);
  assign bus.load_msg      = inRound && (roundIdx == 4'd0);
  assign bus.capture_out   = (state == FINISH);
  assign bus.done          = (state == FINISH);
  assign bus.busy          = (state != IDLE);
  assign bus.error         = errorFlag;

endmodule

// File: tb/tb_aes_round_scheduler.sv
// Directed bench for aes_round_scheduler: full blocks for each key size,
// key reuse, timeout/error recovery and mid-block reset.
module tb_aes_round_scheduler;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   roundPulses = 0;
  int   keyexpPulses = 0;
  int   donePulses = 0;

  always #5 clk = ~clk;

  aes_round_scheduler_if bus();

  aes_round_scheduler #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always @(negedge clk) begin
    if (bus.round_start)  roundPulses++;
    if (bus.keyexp_start) keyexpPulses++;
    if (bus.done)         donePulses++;
  end

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllLow(input string tag);
    checkEq({tag, " busy"}, bus.busy, 0);
    checkEq({tag, " done"}, bus.done, 0);
    checkEq({tag, " capture_out"}, bus.capture_out, 0);
    checkEq({tag, " round_start"}, bus.round_start, 0);
    checkEq({tag, " keyexp_start"}, bus.keyexp_start, 0);
    checkEq({tag, " round_idx"}, bus.round_idx, 0);
    checkEq({tag, " key_sel"}, bus.key_sel, 0);
    checkEq({tag, " initial_round"}, bus.initial_round, 0);
    checkEq({tag, " final_round"}, bus.final_round, 0);
    checkEq({tag, " load_msg"}, bus.load_msg, 0);
  endtask

  // lateRound: round_done arrives on the timeout expiry cycle (must still win).
  // busyRound: a start pulse is injected while busy (must be ignored).
  task automatic runBlock(input string name, input logic enc, input logic [2:0] ks,
                          input logic reload, input logic expKeyexp, input int nr,
                          input int lateRound, input int busyRound);
    int rsBefore, kxBefore, dnBefore, expSel;
    rsBefore = roundPulses;
    kxBefore = keyexpPulses;
    dnBefore = donePulses;
    bus.start      = 1'b1;
    bus.enc_or_dec = enc;
    bus.key_size   = ks;
    bus.key_reload = reload;
    tick();
    bus.start      = 1'b0;
    bus.key_reload = 1'b0;
    bus.enc_or_dec = ~enc;
    bus.key_size   = 3'b111;
    checkEq({name, " busy"}, bus.busy, 1);
    checkEq({name, " error cleared"}, bus.error, 0);
    if (expKeyexp) begin
      checkEq({name, " keyexp_start"}, bus.keyexp_start, 1);
      checkEq({name, " no early round_start"}, bus.round_start, 0);
      tick();
      checkEq({name, " keyexp_start one cycle"}, bus.keyexp_start, 0);
      tick();
      bus.keyexp_done = 1'b1;
      tick();
      bus.keyexp_done = 1'b0;
    end else begin
      checkEq({name, " no keyexp_start"}, bus.keyexp_start, 0);
    end
    for (int r = 0; r <= nr; r++) begin
      expSel = enc ? r : nr - r;
      checkEq($sformatf("%s r%0d round_start", name, r), bus.round_start, 1);
      checkEq($sformatf("%s r%0d round_idx", name, r), bus.round_idx, r);
      checkEq($sformatf("%s r%0d key_sel", name, r), bus.key_sel, expSel);
      checkEq($sformatf("%s r%0d initial_round", name, r), bus.initial_round, (r == 0));
      checkEq($sformatf("%s r%0d final_round", name, r), bus.final_round, (r == nr));
      checkEq($sformatf("%s r%0d load_msg", name, r), bus.load_msg, (r == 0));
      tick();
      checkEq($sformatf("%s r%0d round_start one cycle", name, r), bus.round_start, 0);
      checkEq($sformatf("%s r%0d key_sel held", name, r), bus.key_sel, expSel);
      checkEq($sformatf("%s r%0d final_round held", name, r), bus.final_round, (r == nr));
      checkEq($sformatf("%s r%0d initial_round held", name, r), bus.initial_round, (r == 0));
      if (r == busyRound) begin
        bus.start      = 1'b1;
        bus.key_size   = KEY_SIZE_256;
        bus.key_reload = 1'b1;
        tick();
        bus.start      = 1'b0;
        bus.key_reload = 1'b0;
      end else begin
        tick();
      end
      if (r == lateRound) repeat (6) tick();
      bus.round_done = 1'b1;
      tick();
      bus.round_done = 1'b0;
    end
    checkEq({name, " done"}, bus.done, 1);
    checkEq({name, " capture_out"}, bus.capture_out, 1);
    checkEq({name, " no error"}, bus.error, 0);
    tick();
    checkEq({name, " done one cycle"}, bus.done, 0);
    checkEq({name, " capture_out one cycle"}, bus.capture_out, 0);
    checkEq({name, " idle"}, bus.busy, 0);
    checkEq({name, " round_idx cleared"}, bus.round_idx, 0);
    tick();
    checkEq({name, " stays idle"}, bus.busy, 0);
    checkEq({name, " round count"}, roundPulses - rsBefore, nr + 1);
    checkEq({name, " keyexp count"}, keyexpPulses - kxBefore, expKeyexp ? 1 : 0);
    checkEq({name, " done count"}, donePulses - dnBefore, 1);
  endtask

  initial begin
    int waitCycles;
    int dnBefore;
    bus.start       = 1'b0;
    bus.enc_or_dec  = 1'b0;
    bus.key_size    = 3'b000;
    bus.key_reload  = 1'b0;
    bus.keyexp_done = 1'b0;
    bus.round_done  = 1'b0;
    #1;
    checkAllLow("reset");
    checkEq("reset error", bus.error, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    tick();
    checkAllLow("post-reset idle");

    runBlock("enc128", 1'b1, 3'b001, 1'b0, 1'b1, 10, -1, 3);
    runBlock("reuse128", 1'b1, 3'b001, 1'b0, 1'b0, 10, 0, -1);
    runBlock("enc192", 1'b1, 3'b010, 1'b0, 1'b1, 12, -1, -1);
    runBlock("dec256", 1'b0, 3'b100, 1'b0, 1'b1, 14, -1, -1);
    runBlock("reload256", 1'b0, 3'b100, 1'b1, 1'b1, 14, -1, -1);

    // Timeout: round_done never arrives for round 0.
    bus.start      = 1'b1;
    bus.enc_or_dec = 1'b1;
    bus.key_size   = 3'b001;
    tick();
    bus.start = 1'b0;
    checkEq("timeout keyexp_start", bus.keyexp_start, 1);
    tick();
    bus.keyexp_done = 1'b1;
    tick();
    bus.keyexp_done = 1'b0;
    checkEq("timeout round_start", bus.round_start, 1);
    tick();
    waitCycles = 0;
    while (!bus.error && waitCycles < 20) begin
      tick();
      waitCycles++;
    end
    checkEq("timeout wait cycles", waitCycles, 8);
    checkEq("timeout error", bus.error, 1);
    checkEq("timeout busy in ERR", bus.busy, 1);
    tick();
    checkEq("timeout back to idle", bus.busy, 0);
    checkEq("timeout error sticky", bus.error, 1);
    tick();
    checkEq("timeout error still sticky", bus.error, 1);
    runBlock("post-error", 1'b1, 3'b001, 1'b0, 1'b1, 10, -1, -1);

    // Reset during RWAIT of round 5.
    dnBefore = donePulses;
    bus.start      = 1'b1;
    bus.enc_or_dec = 1'b1;
    bus.key_size   = 3'b001;
    tick();
    bus.start = 1'b0;
    checkEq("abort no keyexp", bus.keyexp_start, 0);
    for (int r = 0; r <= 5; r++) begin
      tick();
      if (r < 5) begin
        bus.round_done = 1'b1;
        tick();
        bus.round_done = 1'b0;
      end
    end
    checkEq("abort round_idx before reset", bus.round_idx, 5);
    #2 rst = 1'b0;
    #1;
    checkAllLow("abort");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    tick();
    checkEq("abort no done pulse", donePulses - dnBefore, 0);
    checkAllLow("abort idle");
    runBlock("post-abort", 1'b1, 3'b001, 1'b0, 1'b1, 10, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_round_scheduler.md
AES_ROUND_SCHEDULER -- requirements
Module: aes_round_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum cycles to wait for any done handshake before flagging an error.
REQ-002 SHALL have port clk  input  1  system clock; single clock domain.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request one block operation; sampled only in IDLE.
REQ-005 SHALL have port enc_or_dec  input  1  1 = encrypt, 0 = decrypt; latched on accepted start.
REQ-006 SHALL have port key_size  input  3  encoding 3'b100 = 256-bit, 3'b010 = 192-bit, any other value = 128-bit; latched on accepted start.
REQ-007 SHALL have port key_reload  input  1  force key expansion even when a valid expanded key is held.
REQ-008 SHALL have port keyexp_start  output  1  one-cycle pulse starting key expansion.
REQ-009 SHALL have port keyexp_done  input  1  key expansion complete (level or pulse).
REQ-010 SHALL have port round_start  output  1  one-cycle pulse issuing one round to the round engine.
REQ-011 SHALL have port round_done  input  1  round engine finished the current round.
REQ-012 SHALL have port round_idx  output  4  current round index, 0..Nr.
REQ-013 SHALL have port key_sel  output  4  round-key index presented to key control.
REQ-014 SHALL have port initial_round, final_round  output  1 each  round-type flags for the round engine.
REQ-015 SHALL have port load_msg  output  1  select the external message (not feedback) as round input.
REQ-016 SHALL have port capture_out  output  1  one-cycle strobe to register the final state into the message output.
REQ-017 SHALL have ports busy, done, error  output  1 each  busy = not IDLE; done = one-cycle completion pulse; error = timeout flag.

Function
REQ-018 SHALL implement the FSM states IDLE, KEYEXP, KEYWAIT, ISSUE, RWAIT, FINISH, ERR.
REQ-019 SHALL set Nr = 10, 12 or 14 from the latched key_size, and SHALL issue exactly Nr+1 rounds per block.
REQ-020 IDLE with start=1 SHALL go to KEYEXP if key_reload=1, if no valid key is held, or if the latched key_size differs from the held key_size; otherwise it SHALL go directly to ISSUE.
REQ-021 KEYEXP SHALL assert keyexp_start for one cycle and then move to KEYWAIT.
REQ-022 KEYWAIT SHALL move to ISSUE on the first cycle keyexp_done=1, and SHALL set key_valid and record the held key_size.
REQ-023 ISSUE SHALL assert round_start for one cycle and then move to RWAIT.
REQ-024 RWAIT on round_done=1 SHALL go to FINISH if round_idx==Nr; otherwise it SHALL increment round_idx and go to ISSUE.
REQ-025 FINISH SHALL pulse done and capture_out together for one cycle, clear round_idx to 0, and return to IDLE.
REQ-026 initial_round SHALL equal (round_idx==0), and final_round SHALL equal (round_idx==Nr); both SHALL be held valid from ISSUE through RWAIT.
REQ-027 key_sel SHALL equal round_idx when encrypting and Nr-round_idx when decrypting.
REQ-028 load_msg SHALL be high only in ISSUE/RWAIT with round_idx==0.
REQ-029 keyexp_done and round_done SHALL be ignored outside KEYWAIT and RWAIT respectively.
REQ-030 start while busy SHALL be ignored, with no queuing.
REQ-031 The timeout counter SHALL clear on entry to KEYWAIT or RWAIT and increment each cycle while waiting.
REQ-032 When the timeout counter reaches TIMEOUT_CYCLES-1 without a handshake, the FSM SHALL go to ERR.
REQ-033 ERR SHALL set error (sticky), clear key_valid, and return to IDLE the next cycle.
REQ-034 error SHALL clear on the next accepted start.
REQ-035 A handshake arriving on the same cycle the timeout expires SHALL win; the FSM proceeds normally.

Reset
REQ-036 rst=0 SHALL asynchronously force IDLE and clear round_idx, the timeout counter, key_valid, the latched controls, and all outputs to 0.
REQ-037 Reset mid-operation SHALL abandon the block with no done or capture_out pulse.

Structure
REQ-038 The FSM state enum, key_size encodings, and the Nr constants (10/12/14) SHALL live in shared package aes_pkg.
REQ-039 The timeout counter SHALL be a sub-module aes_timeout_counter (clear, enable, expired).
REQ-040 The block SHALL contain no datapath; message and key buses stay outside it.

Verification
REQ-041 Encrypt-128 test: start with key_size=001 -> one keyexp_start pulse; after keyexp_done, 11 round_start pulses with key_sel 0..10; load_msg only on round 0; final_round on round 10; done and capture_out one cycle after the 11th round_done.
REQ-042 Decrypt-256 test: key_size=100, enc_or_dec=0 -> 15 rounds with key_sel 14..0; initial_round on key_sel 14; final_round on key_sel 0.
REQ-043 Key-reuse test: a second 128-bit start with key_reload=0 -> no keyexp_start and round_start on the cycle after start.
REQ-044 Key-reuse test: a second start with key_size changed to 010 -> keyexp_start reissued, then 13 rounds.
REQ-045 Timeout test: TIMEOUT_CYCLES=8 with round_done held low -> error=1 after 8 wait cycles, then IDLE; next start clears error and forces key expansion.
REQ-046 Robustness test: reset asserted during RWAIT of round 5 -> all outputs 0 immediately with no done pulse; a start pulse during busy is ignored, confirmed by the exact round count.
